dbank_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port 128 x 16 data bank. It sits between the bank and two masters: the CPU datapath (load/store) and a DMA/debug loader that fills or dumps the bank. Each cycle it issues at most one access, using round-robin with a bounded burst length. It also steers the one-cycle-delayed read data back to the master that issued the read.

---
 rtl/dbank_arbiter.sv | 126 ++++++++++++
 tb/tb_dbank_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/dbank_arbiter.sv
// Round-robin arbiter with bounded bursts between the CPU and the DMA loader
// for the single-port data bank; also steers one-cycle-delayed read data back.
module dbank_arbiter #(
  parameter int AW        = 7,
  parameter int DW        = 16,
  parameter int MAX_BURST = 4
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int            CW      = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, OWN_CPU, OWN_DMA} state_t;

  state_t        state, state_nxt;
  logic          last, last_nxt;   // 1 = DMA was served last
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = (cnt == MAX_CNT) ? MAX_CNT : cnt + CW'(1);

  // Grant decision: the owner keeps the bank until its burst is spent while
  // the other side waits; reset suppresses every grant.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (cpu_req && dma_req) begin
            cpu_gnt = last;
            dma_gnt = !last;
          end else begin
            cpu_gnt = cpu_req;
            dma_gnt = dma_req;
          end
        end
        OWN_CPU: begin
          if (cpu_req && ((cnt < MAX_CNT) || !dma_req)) cpu_gnt = 1'b1;
          else                                          dma_gnt = dma_req;
        end
        OWN_DMA: begin
          if (dma_req && ((cnt < MAX_CNT) || !cpu_req)) dma_gnt = 1'b1;
          else                                          cpu_gnt = cpu_req;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = IDLE;
    last_nxt  = last;
    cnt_nxt   = '0;
    if (cpu_gnt) begin
      state_nxt = OWN_CPU;
      last_nxt  = 1'b0;
      cnt_nxt   = (state == OWN_CPU) ? cnt_inc : CW'(1);
    end else if (dma_gnt) begin
      state_nxt = OWN_DMA;
      last_nxt  = 1'b1;
      cnt_nxt   = (state == OWN_DMA) ? cnt_inc : CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state      <= IDLE;
      last       <= 1'b1;
      cnt        <= '0;
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
    end else begin
      state      <= state_nxt;
      last       <= last_nxt;
      cnt        <= cnt_nxt;
      cpu_rvalid <= cpu_gnt && !cpu_we;
      dma_rvalid <= dma_gnt && !dma_we;
    end
  end

  // Bank port: idle drives zeros so the bus is quiet between accesses.
  always_comb begin
    mem_en    = cpu_gnt | dma_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_gnt) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  assign cpu_rdata = mem_rdata;
  assign dma_rdata = mem_rdata;

endmodule

// File: tb/tb_dbank_arbiter.sv
// Directed bench for dbank_arbiter with a behavioural 128x16 bank and a
// read-return scoreboard fed at grant time and drained when rvalid is due.
module tb_dbank_arbiter;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [6:0]  cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_gnt, dma_rvalid;
  logic [6:0]  dma_addr;
  logic [15:0] dma_wdata, dma_rdata;
  logic        mem_en, mem_we;
  logic [6:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic        dma;
    logic [15:0] data;
  } rd_t;

  rd_t         rq[$];
  logic [15:0] exp_bank [128];
  logic [15:0] bank     [128];

  always #5 clk1 = ~clk1;

  dbank_arbiter dut (
    .clk1(clk1), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Single-port bank: write commits at the edge, read data appears next cycle.
  always @(posedge clk1) begin
    if (mem_en) begin
      if (mem_we) bank[mem_addr] <= mem_wdata;
      else        mem_rdata      <= bank[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [6:0] a, input logic [15:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_dma(input logic req, input logic we, input logic [6:0] a, input logic [15:0] d);
    dma_req = req; dma_we = we; dma_addr = a; dma_wdata = d;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle(input logic ec, input logic ed, input string tag);
    logic        ewe;
    logic [6:0]  ea;
    logic [15:0] ewd;
    rd_t         it;
    ewe = 1'b0; ea = '0; ewd = '0;
    if (ec) begin
      ewe = cpu_we; ea = cpu_addr; ewd = cpu_wdata;
    end else if (ed) begin
      ewe = dma_we; ea = dma_addr; ewd = dma_wdata;
    end
    #1;
    check({tag, ".cpu_gnt"},   cpu_gnt,   ec);
    check({tag, ".dma_gnt"},   dma_gnt,   ed);
    check({tag, ".mem_en"},    mem_en,    ec | ed);
    check({tag, ".mem_we"},    mem_we,    ewe);
    check({tag, ".mem_addr"},  mem_addr,  ea);
    check({tag, ".mem_wdata"}, mem_wdata, ewd);
    if (ec || ed) begin
      if (ewe) exp_bank[ea] = ewd;
      else     rq.push_back('{dma: ed, data: exp_bank[ea]});
    end
    @(posedge clk1);
    #1;
    if (rq.size() > 0) begin
      it = rq.pop_front();
      check({tag, ".cpu_rvalid"}, cpu_rvalid, !it.dma);
      check({tag, ".dma_rvalid"}, dma_rvalid, it.dma);
      if (it.dma) check({tag, ".dma_rdata"}, dma_rdata, it.data);
      else        check({tag, ".cpu_rdata"}, cpu_rdata, it.data);
    end else begin
      check({tag, ".cpu_rvalid_idle"}, cpu_rvalid, 1'b0);
      check({tag, ".dma_rvalid_idle"}, dma_rvalid, 1'b0);
    end
    @(negedge clk1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  cn, dn;
    logic ec;
    rst = 1'b1;
    set_cpu(1'b1, 1'b1, 7'd5, 16'hBEEF);
    set_dma(1'b1, 1'b1, 7'd100, 16'h5555);
    @(negedge clk1);

    // Reset held with both masters requesting: nothing may be granted.
    repeat (3) cycle(1'b0, 1'b0, "reset");
    rst = 1'b0;

    // CPU write BEEF to 5 wins first, then reads it back while DMA waits.
    cycle(1'b1, 1'b0, "cpu_wr5");
    set_cpu(1'b1, 1'b0, 7'd5, 16'h0);
    cycle(1'b1, 1'b0, "cpu_rd5");
    set_cpu(1'b0, 1'b0, 7'd0, 16'h0);
    cycle(1'b0, 1'b1, "dma_wr100");
    set_dma(1'b0, 1'b0, 7'd0, 16'h0);
    cycle(1'b0, 1'b0, "idle0");

    // DMA alone fills bank[i] = i with no gaps, well past MAX_BURST.
    for (int i = 0; i < 10; i++) begin
      set_dma(1'b1, 1'b1, 7'(i), 16'(i));
      cycle(1'b0, 1'b1, "dma_fill");
    end
    set_dma(1'b0, 1'b0, 7'd0, 16'h0);
    cycle(1'b0, 1'b0, "idle1");

    // Continuous contention: four grants each, CPU first since DMA was last.
    cn = 0; dn = 0;
    for (int i = 0; i < 20; i++) begin
      set_cpu(1'b1, 1'b1, 7'(20 + cn), 16'(16'h1000 + cn));
      set_dma(1'b1, 1'b1, 7'(40 + dn), 16'(16'h2000 + dn));
      ec = ((i / 4) % 2) == 0;
      cycle(ec, !ec, "contend");
      if (ec) cn++;
      else    dn++;
    end
    set_cpu(1'b0, 1'b0, 7'd0, 16'h0);
    set_dma(1'b0, 1'b0, 7'd0, 16'h0);
    cycle(1'b0, 1'b0, "idle2");

    // CPU reads back the DMA fill.
    for (int i = 0; i < 10; i++) begin
      set_cpu(1'b1, 1'b0, 7'(i), 16'h0);
      cycle(1'b1, 1'b0, "cpu_readback");
    end
    set_cpu(1'b0, 1'b0, 7'd0, 16'h0);
    cycle(1'b0, 1'b0, "idle3");

    // Interleaved reads by different masters in consecutive cycles.
    set_cpu(1'b1, 1'b0, 7'd1, 16'h0);
    cycle(1'b1, 1'b0, "ilv_cpu_rd1");
    set_cpu(1'b0, 1'b0, 7'd0, 16'h0);
    set_dma(1'b1, 1'b0, 7'd2, 16'h0);
    cycle(1'b0, 1'b1, "ilv_dma_rd2");
    set_dma(1'b0, 1'b0, 7'd0, 16'h0);
    cycle(1'b0, 1'b0, "idle4");

    // Reset in the middle of a DMA read burst, then fresh arbitration.
    set_dma(1'b1, 1'b0, 7'd3, 16'h0);
    cycle(1'b0, 1'b1, "burst_rd3");
    set_dma(1'b1, 1'b0, 7'd4, 16'h0);
    cycle(1'b0, 1'b1, "burst_rd4");
    set_cpu(1'b1, 1'b0, 7'd5, 16'h0);
    rst = 1'b1;
    cycle(1'b0, 1'b0, "rst_mid_burst");
    rst = 1'b0;
    cycle(1'b1, 1'b0, "post_rst_cpu_rd5");
    set_cpu(1'b0, 1'b0, 7'd0, 16'h0);
    cycle(1'b0, 1'b1, "post_rst_dma_rd4");
    set_dma(1'b0, 1'b0, 7'd0, 16'h0);
    cycle(1'b0, 1'b0, "idle5");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
